// File: rtl/tr_loop_sequencer_if.sv
// Control/status bundle between the packet/correlator control and the
// timing-recovery loop sequencer.
interface tr_loop_sequencer_if;
    logic       enable;
    logic [1:0] mode_in;
    logic       update_data;
    logic       aa_match;
    logic       pkt_end;
    logic       tr_rst_n;
    logic [1:0] tr_select;
    logic [2:0] tr_sample_point;
    logic [3:0] tr_e_k_shift;
    logic [4:0] tr_tau_shift;
    logic [2:0] state;
    logic       locked;
    logic       timeout_evt;

    modport master (
        output enable, mode_in, update_data, aa_match, pkt_end,
        input  tr_rst_n, tr_select, tr_sample_point, tr_e_k_shift,
               tr_tau_shift, state, locked, timeout_evt
    );

    modport slave (
        input  enable, mode_in, update_data, aa_match, pkt_end,
        output tr_rst_n, tr_select, tr_sample_point, tr_e_k_shift,
               tr_tau_shift, state, locked, timeout_evt
    );
endinterface

// File: rtl/tr_loop_sequencer.sv
// Timing-recovery loop sequencer: clear, high-gain acquisition, low-gain tracking, lock hold.
// Optional macro TR_GEAR_SHIFT_EN: step the loop gain down gradually through TRACK.
module tr_loop_sequencer #(
    parameter int RST_CYCLES      = 4,
    parameter int ACQ_SYMBOLS     = 8,
    parameter int TIMEOUT_SYMBOLS = 512,
    parameter int ACQ_EK_SHIFT    = 1,
    parameter int TRK_EK_SHIFT    = 3,
    parameter int TAU_SHIFT_BLE   = 10,
    parameter int TAU_SHIFT_154   = 11,
    parameter int SAMPLE_POINT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    tr_loop_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_ACQ    = 3'd2;
    localparam logic [2:0] ST_TRACK  = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam logic [3:0] CYC_LAST = 4'(RST_CYCLES - 1);
    localparam logic [9:0] ACQ_LAST = 10'(ACQ_SYMBOLS - 1);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_SYMBOLS - 1);
    localparam logic [3:0] EK_ACQ   = 4'(ACQ_EK_SHIFT);
    localparam logic [3:0] EK_TRK   = 4'(TRK_EK_SHIFT);
    localparam logic [4:0] TAU_BLE  = 5'(TAU_SHIFT_BLE);
    localparam logic [4:0] TAU_154  = 5'(TAU_SHIFT_154);
    localparam logic [2:0] SMP_PT   = 3'(SAMPLE_POINT);
`ifdef TR_GEAR_SHIFT_EN
    localparam logic [3:0] EK_TRK_ENTRY = (ACQ_EK_SHIFT < TRK_EK_SHIFT) ? 4'(ACQ_EK_SHIFT + 1) : EK_TRK;
`else
    localparam logic [3:0] EK_TRK_ENTRY = EK_TRK;
`endif

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        if (v == 10'h3FF) begin
            return v;
        end else begin
            return v + 10'd1;
        end
    endfunction

    logic [2:0] state_r, state_nxt_s;
    logic [3:0] cyc_cnt_r, cyc_cnt_nxt_s;
    logic [9:0] sym_cnt_r, sym_cnt_nxt_s;
    logic       tr_rst_n_r, tr_rst_n_nxt_s;
    logic [1:0] tr_select_r, tr_select_nxt_s;
    logic [3:0] ek_r, ek_nxt_s;
    logic [4:0] tau_r, tau_nxt_s;
    logic       locked_r, locked_nxt_s;
    logic       timeout_r, timeout_nxt_s;
`ifdef TR_GEAR_SHIFT_EN
    logic [9:0] gear_cnt_r, gear_cnt_nxt_s;
`endif

    // Next-state selection; enable low overrides every other event
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_CLEAR;
                ST_CLEAR: begin
                    if (cyc_cnt_r == CYC_LAST) state_nxt_s = ST_ACQ;
                    else                       state_nxt_s = ST_CLEAR;
                end
                ST_ACQ: begin
                    if (bus.aa_match)                                     state_nxt_s = ST_LOCKED;
                    else if (bus.update_data && (sym_cnt_r == ACQ_LAST)) state_nxt_s = ST_TRACK;
                    else                                                  state_nxt_s = ST_ACQ;
                end
                ST_TRACK: begin
                    if (bus.aa_match)                                     state_nxt_s = ST_LOCKED;
                    else if (bus.update_data && (sym_cnt_r == TMO_LAST)) state_nxt_s = ST_CLEAR;
                    else                                                  state_nxt_s = ST_TRACK;
                end
                ST_LOCKED: begin
                    if (bus.pkt_end) state_nxt_s = ST_CLEAR;
                    else             state_nxt_s = ST_LOCKED;
                end
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output and counter next values; outputs only move on a state entry (or a gear step)
    always_comb begin
        cyc_cnt_nxt_s   = cyc_cnt_r;
        sym_cnt_nxt_s   = sym_cnt_r;
        tr_rst_n_nxt_s  = tr_rst_n_r;
        tr_select_nxt_s = tr_select_r;
        ek_nxt_s        = ek_r;
        tau_nxt_s       = tau_r;
        locked_nxt_s    = locked_r;
        timeout_nxt_s   = (state_r == ST_TRACK) && (state_nxt_s == ST_CLEAR);
`ifdef TR_GEAR_SHIFT_EN
        gear_cnt_nxt_s  = gear_cnt_r;
`endif
        if (state_nxt_s != state_r) begin
            cyc_cnt_nxt_s = 4'd0;
            sym_cnt_nxt_s = 10'd0;
`ifdef TR_GEAR_SHIFT_EN
            gear_cnt_nxt_s = 10'd0;
`endif
            case (state_nxt_s)
                ST_CLEAR: begin
                    tr_rst_n_nxt_s  = 1'b0;
                    locked_nxt_s    = 1'b0;
                    ek_nxt_s        = EK_ACQ;
                    tr_select_nxt_s = bus.mode_in;
                    if (bus.mode_in == 2'd1) tau_nxt_s = TAU_154;
                    else                     tau_nxt_s = TAU_BLE;
                end
                ST_ACQ: begin
                    tr_rst_n_nxt_s = 1'b1;
                    locked_nxt_s   = 1'b0;
                    ek_nxt_s       = EK_ACQ;
                end
                ST_TRACK: begin
                    tr_rst_n_nxt_s = 1'b1;
                    locked_nxt_s   = 1'b0;
                    ek_nxt_s       = EK_TRK_ENTRY;
                end
                ST_LOCKED: begin
                    tr_rst_n_nxt_s = 1'b1;
                    locked_nxt_s   = 1'b1;
                    ek_nxt_s       = EK_TRK;
                end
                default: begin
                    tr_rst_n_nxt_s = 1'b0;
                    locked_nxt_s   = 1'b0;
                    ek_nxt_s       = EK_ACQ;
                end
            endcase
        end else begin
            if (state_r == ST_CLEAR) cyc_cnt_nxt_s = cyc_cnt_r + 4'd1;
            else                     cyc_cnt_nxt_s = cyc_cnt_r;
            if (bus.update_data) sym_cnt_nxt_s = sat_inc10(sym_cnt_r);
            else                 sym_cnt_nxt_s = sym_cnt_r;
`ifdef TR_GEAR_SHIFT_EN
            // Gear steps use their own counter so the timeout budget is unaffected
            if ((state_r == ST_TRACK) && bus.update_data) begin
                if (gear_cnt_r == ACQ_LAST) begin
                    gear_cnt_nxt_s = 10'd0;
                    if (ek_r < EK_TRK) ek_nxt_s = ek_r + 4'd1;
                    else               ek_nxt_s = ek_r;
                end else begin
                    gear_cnt_nxt_s = gear_cnt_r + 10'd1;
                end
            end else begin
                gear_cnt_nxt_s = gear_cnt_r;
            end
`endif
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cyc_cnt_r   <= 4'd0;
            sym_cnt_r   <= 10'd0;
            tr_rst_n_r  <= 1'b0;
            tr_select_r <= 2'd0;
            ek_r        <= EK_ACQ;
            tau_r       <= TAU_BLE;
            locked_r    <= 1'b0;
            timeout_r   <= 1'b0;
`ifdef TR_GEAR_SHIFT_EN
            gear_cnt_r  <= 10'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cyc_cnt_r   <= cyc_cnt_nxt_s;
            sym_cnt_r   <= sym_cnt_nxt_s;
            tr_rst_n_r  <= tr_rst_n_nxt_s;
            tr_select_r <= tr_select_nxt_s;
            ek_r        <= ek_nxt_s;
            tau_r       <= tau_nxt_s;
            locked_r    <= locked_nxt_s;
            timeout_r   <= timeout_nxt_s;
`ifdef TR_GEAR_SHIFT_EN
            gear_cnt_r  <= gear_cnt_nxt_s;
`endif
        end
    end

    assign bus.state           = state_r;
    assign bus.tr_rst_n        = tr_rst_n_r;
    assign bus.tr_select       = tr_select_r;
    assign bus.tr_sample_point = SMP_PT;
    assign bus.tr_e_k_shift    = ek_r;
    assign bus.tr_tau_shift    = tau_r;
    assign bus.locked          = locked_r;
    assign bus.timeout_evt     = timeout_r;

endmodule

// File: doc/tr_loop_sequencer.md
Name: tr_loop_sequencer

Overview:
- Sequences the BLE / 802.15.4 timing-recovery loop across packet acquisition.
- Clears the loop between packets and selects the mode.
- Runs the loop at high gain during acquisition, then drops to low-gain tracking.
- Holds the loop while a packet is locked; re-arms after packet end or a search timeout.
- Sits between the packet/correlator control and the timing-recovery block's config and reset inputs.

Parameters:
- RST_CYCLES, 4: cycles the loop is held in reset in CLEAR (1..15).
- ACQ_SYMBOLS, 8: update_data pulses spent in ACQ before TRACK (1..1023).
- TIMEOUT_SYMBOLS, 512: update_data pulses in TRACK without aa_match before timeout (1..1023).
- ACQ_EK_SHIFT, 1: e_k shift (high loop gain) during ACQ.
- TRK_EK_SHIFT, 3: e_k shift (low loop gain) during TRACK/LOCKED; must be >= ACQ_EK_SHIFT.
- TAU_SHIFT_BLE, 10: tau shift for BLE mode.
- TAU_SHIFT_154, 11: tau shift for 802.15.4 mode.
- SAMPLE_POINT, 2: sample point driven to the loop.

Ports:
- clk  in  1  16 MHz clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = run the sequencer; 0 = return to IDLE.
- mode_in  in  2  requested mode (1 = 802.15.4, other = BLE).
- update_data  in  1  symbol strobe from the timing-recovery loop.
- aa_match  in  1  single-cycle access-address/SFD match pulse.
- pkt_end  in  1  single-cycle end-of-packet pulse.
- tr_rst_n  out  1  active-low reset to the timing-recovery loop.
- tr_select  out  2  mode to the loop.
- tr_sample_point  out  3  sample point to the loop.
- tr_e_k_shift  out  4  error shift to the loop.
- tr_tau_shift  out  5  tau shift to the loop.
- state  out  3  current state encoding.
- locked  out  1  high while in LOCKED.
- timeout_evt  out  1  one-cycle pulse on search timeout.

Behaviour:
- Reset values:
  - state = IDLE, tr_rst_n = 0, tr_select = 0.
  - tr_sample_point = SAMPLE_POINT, tr_e_k_shift = ACQ_EK_SHIFT, tr_tau_shift = TAU_SHIFT_BLE.
  - locked = 0, timeout_evt = 0, all counters 0.
- All outputs are registered; each takes its new value in the same cycle the state register changes.
- States: IDLE = 0, CLEAR = 1, ACQ = 2, TRACK = 3, LOCKED = 4. Encodings 5–7 are illegal and go to IDLE on the next clock.
- IDLE:
  - tr_rst_n = 0.
  - enable = 1 → CLEAR, and latch mode_in into tr_select.
  - tr_tau_shift = TAU_SHIFT_154 if the latched mode is 1, else TAU_SHIFT_BLE.
- CLEAR:
  - tr_rst_n = 0 for exactly RST_CYCLES cycles (cycle counter), then → ACQ.
  - Mode is re-latched from mode_in on every entry to CLEAR.
- ACQ:
  - tr_rst_n = 1, tr_e_k_shift = ACQ_EK_SHIFT.
  - The symbol counter increments on each update_data pulse.
  - When the count reaches ACQ_SYMBOLS → TRACK.
  - aa_match → LOCKED directly.
- TRACK:
  - tr_e_k_shift = TRK_EK_SHIFT.
  - aa_match → LOCKED.
  - Symbol count reaches TIMEOUT_SYMBOLS → pulse timeout_evt for 1 cycle, then → CLEAR (loop re-cleared).
- LOCKED:
  - locked = 1, e_k shift held at TRK_EK_SHIFT.
  - pkt_end → CLEAR.
- Symbol counter: 10 bits, cleared on every state entry, saturates at 1023.
- tr_select / tr_tau_shift never change outside IDLE/CLEAR entry; mid-packet changes of mode_in are ignored.
- Priority when events coincide in one cycle:
  - enable = 0 wins over everything: → IDLE next cycle, tr_rst_n = 0, locked = 0.
  - aa_match wins over a timeout or an ACQ→TRACK transition in the same cycle.
  - pkt_end outside LOCKED is ignored; aa_match in IDLE/CLEAR/LOCKED is ignored.
- An update_data pulse in the same cycle as a state transition is not counted in the new state.
- Asserting rst mid-operation forces all reset values immediately; the loop is held in reset (tr_rst_n = 0).

Optional Feature:
- Macro: TR_GEAR_SHIFT_EN.
- Defined:
  - On entry to TRACK, tr_e_k_shift starts at ACQ_EK_SHIFT + 1.
  - It increments by 1 every ACQ_SYMBOLS update_data pulses until it reaches TRK_EK_SHIFT.
  - Gear-step counting is separate from the timeout count.
  - LOCKED forces TRK_EK_SHIFT immediately.
- Undefined: tr_e_k_shift jumps from ACQ_EK_SHIFT to TRK_EK_SHIFT on TRACK entry.

Test Plan:
- Defaults; assert rst, release, enable = 1, mode_in = 1 → tr_rst_n low exactly 4 cycles, state 0→1→2, tr_select = 1, tr_tau_shift = 11, tr_e_k_shift = 1.
- In ACQ, 8 update_data pulses → state = 3 and tr_e_k_shift = 3 on the cycle after the 8th pulse; aa_match → state = 4, locked = 1.
- In TRACK, 512 update_data pulses with no aa_match → timeout_evt high 1 cycle, state = 1, tr_rst_n = 0 for 4 cycles, then ACQ again.
- aa_match coincident with the 512th pulse → LOCKED, no timeout_evt.
- In LOCKED, change mode_in to 0, then pkt_end → CLEAR, tr_select = 0, tr_tau_shift = 10; pkt_end while in ACQ → ignored.
- enable dropped in TRACK → IDLE next cycle, tr_rst_n = 0. With TR_GEAR_SHIFT_EN, ACQ_EK_SHIFT = 1, TRK_EK_SHIFT = 4 → tr_e_k_shift reads 2, 3, 4 at TRACK entry, +8 pulses, +16 pulses.
